// File: rtl/tile_scheduler.sv
// Walks one layer's K/N/D tile space and issues tile commands over valid/ready.
// Optional TILE_SCHED_PERF_EN adds stall_cycles and cmd_count performance counters.
module tile_scheduler #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       layer_type,
   input  logic [7:0]       in_C,
   input  logic [7:0]       out_C,
   input  logic [7:0]       tile_D,
   input  logic [7:0]       tile_K,
   input  logic [31:0]      tile_n,
   input  logic [CNT_W-1:0] total_n,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [7:0]       cmd_k_base,
   output logic [7:0]       cmd_k_len,
   output logic [7:0]       cmd_d_base,
   output logic [7:0]       cmd_d_len,
   output logic [CNT_W-1:0] cmd_n_base,
   output logic [CNT_W-1:0] cmd_n_len,
   output logic             cmd_first_d,
   output logic             cmd_last_d,
   output logic             busy,
   output logic             done,
`ifdef TILE_SCHED_PERF_EN
   output logic [31:0]      stall_cycles,
   output logic [31:0]      cmd_count,
`endif
   output logic             err
);

   typedef enum logic [1:0] {StIdle, StCheck, StIssue, StDone} state_e;

   state_e state_q, state_d;

   logic             dw_q;
   logic [7:0]       in_c_q, out_c_q, tile_d_q, tile_k_q;
   logic [31:0]      tile_n_raw_q;
   logic [CNT_W-1:0] tile_n_q, total_n_q;
   logic [7:0]       k_base_q, d_base_q;
   logic [CNT_W-1:0] n_base_q;
   logic             err_q;

   logic [8:0]       k_sum, d_sum;
   logic [CNT_W:0]   n_sum;
   logic             k_wrap, d_end, d_wrap, n_wrap;
   logic [7:0]       k_rem, d_rem, k_len, d_len;
   logic [CNT_W-1:0] n_rem, n_len, tile_n_clamp;
   logic             issue, accept, launch, param_zero;

   // One bit wider than the bases so a sum past the limit cannot alias below it.
   assign k_sum  = {1'b0, k_base_q} + {1'b0, tile_k_q};
   assign d_sum  = {1'b0, d_base_q} + {1'b0, tile_d_q};
   assign n_sum  = {1'b0, n_base_q} + {1'b0, tile_n_q};
   assign k_wrap = k_sum >= {1'b0, out_c_q};
   assign d_end  = d_sum >= {1'b0, in_c_q};
   assign d_wrap = dw_q | d_end;
   assign n_wrap = n_sum >= {1'b0, total_n_q};

   assign k_rem = out_c_q - k_base_q;
   assign d_rem = in_c_q - d_base_q;
   assign n_rem = total_n_q - n_base_q;
   assign k_len = (tile_k_q < k_rem) ? tile_k_q : k_rem;
   assign d_len = (tile_d_q < d_rem) ? tile_d_q : d_rem;
   assign n_len = (tile_n_q < n_rem) ? tile_n_q : n_rem;

   assign issue  = (state_q == StIssue);
   assign accept = issue & cmd_ready;
   assign launch = (state_q == StIdle) & start;

   assign param_zero = (tile_n_raw_q == 32'd0) | (tile_d_q == 8'd0) | (tile_k_q == 8'd0) |
                       (in_c_q == 8'd0) | (out_c_q == 8'd0) | (total_n_q == '0);
   assign tile_n_clamp = (tile_n_raw_q > 32'(total_n_q)) ? total_n_q
                                                         : tile_n_raw_q[CNT_W-1:0];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StCheck;
         StCheck: state_d = param_zero ? StDone : StIssue;
         StIssue: if (accept && d_wrap && n_wrap && k_wrap) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dw_q         <= 1'b0;
         in_c_q       <= '0;
         out_c_q      <= '0;
         tile_d_q     <= '0;
         tile_k_q     <= '0;
         tile_n_raw_q <= '0;
         tile_n_q     <= '0;
         total_n_q    <= '0;
         k_base_q     <= '0;
         d_base_q     <= '0;
         n_base_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         if (launch) begin
            dw_q         <= (layer_type == 2'd1);
            in_c_q       <= in_C;
            out_c_q      <= out_C;
            tile_d_q     <= tile_D;
            tile_k_q     <= tile_K;
            tile_n_raw_q <= tile_n;
            total_n_q    <= total_n;
            err_q        <= 1'b0;
         end
         if (state_q == StCheck) begin
            tile_n_q <= tile_n_clamp;
            k_base_q <= '0;
            d_base_q <= '0;
            n_base_q <= '0;
            if (param_zero) err_q <= 1'b1;
         end
         // Odometer: D innermost (skipped for depthwise), then N, then K.
         if (accept) begin
            if (!d_wrap) begin
               d_base_q <= d_sum[7:0];
            end else begin
               d_base_q <= '0;
               if (!n_wrap) begin
                  n_base_q <= n_sum[CNT_W-1:0];
               end else begin
                  n_base_q <= '0;
                  if (!k_wrap) k_base_q <= k_sum[7:0];
               end
            end
         end
      end
   end

   always_comb begin
      cmd_valid   = 1'b0;
      cmd_k_base  = '0;
      cmd_k_len   = '0;
      cmd_d_base  = '0;
      cmd_d_len   = '0;
      cmd_n_base  = '0;
      cmd_n_len   = '0;
      cmd_first_d = 1'b0;
      cmd_last_d  = 1'b0;
      if (issue) begin
         cmd_valid   = 1'b1;
         cmd_k_base  = k_base_q;
         cmd_k_len   = k_len;
         cmd_n_base  = n_base_q;
         cmd_n_len   = n_len;
         cmd_d_base  = dw_q ? k_base_q : d_base_q;
         cmd_d_len   = dw_q ? k_len : d_len;
         cmd_first_d = dw_q | (d_base_q == 8'd0);
         cmd_last_d  = dw_q | d_end;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign err  = err_q;

`ifdef TILE_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         cmd_count    <= '0;
      end else if (launch) begin
         stall_cycles <= '0;
         cmd_count    <= '0;
      end else begin
         if (issue && !cmd_ready && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
         if (accept && (cmd_count != '1)) cmd_count <= cmd_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Randomized scoreboard bench for tile_scheduler; a nested-loop reference model
// predicts each layer's command stream and a negedge monitor checks it.
module tb_tile_scheduler;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [7:0]       kb, kl, db, dl;
      logic [CNT_W-1:0] nb, nl;
      logic             f, l;
   } cmd_t;

   logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, cmd_ready = 1'b0;
   logic [1:0]       layer_type = '0;
   logic [7:0]       in_C = '0, out_C = '0, tile_D = '0, tile_K = '0;
   logic [31:0]      tile_n = '0;
   logic [CNT_W-1:0] total_n = '0;
   logic             cmd_valid, cmd_first_d, cmd_last_d, busy, done, err;
   logic [7:0]       cmd_k_base, cmd_k_len, cmd_d_base, cmd_d_len;
   logic [CNT_W-1:0] cmd_n_base, cmd_n_len;
`ifdef TILE_SCHED_PERF_EN
   logic [31:0]      stall_cycles, cmd_count;
`endif

   tile_scheduler #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .layer_type(layer_type),
      .in_C(in_C), .out_C(out_C), .tile_D(tile_D), .tile_K(tile_K),
      .tile_n(tile_n), .total_n(total_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_k_base(cmd_k_base), .cmd_k_len(cmd_k_len),
      .cmd_d_base(cmd_d_base), .cmd_d_len(cmd_d_len),
      .cmd_n_base(cmd_n_base), .cmd_n_len(cmd_n_len),
      .cmd_first_d(cmd_first_d), .cmd_last_d(cmd_last_d),
      .busy(busy), .done(done),
`ifdef TILE_SCHED_PERF_EN
      .stall_cycles(stall_cycles), .cmd_count(cmd_count),
`endif
      .err(err)
   );

   always #5 clk = ~clk;

   int   errors = 0, checks = 0;
   int   cyc = 0;
   int   rdy_mode = 0;  // 0: never ready, 1: always ready, 2: random
   cmd_t exp_q[$];
   int   done_seen, done_cyc, last_acc_cyc, first_valid_cyc, stalls, accepts;
   bit   first_seen;
   logic err_at_done;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      cmd_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
   end

   // Monitor: compares whatever the DUT presents against the head of the scoreboard.
   initial forever begin
      cmd_t got;
      @(negedge clk);
      if (rst_n) begin
         if (cmd_valid) begin
            if (!first_seen) begin
               first_seen      = 1'b1;
               first_valid_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
               check("no_cmd_expected", 96'(cmd_valid), 96'd0);
            end else begin
               got = '{kb: cmd_k_base, kl: cmd_k_len, db: cmd_d_base, dl: cmd_d_len,
                       nb: cmd_n_base, nl: cmd_n_len, f: cmd_first_d, l: cmd_last_d};
               check("cmd", 96'(got), 96'(exp_q[0]));
               if (cmd_ready) begin
                  void'(exp_q.pop_front());
                  last_acc_cyc = cyc;
                  accepts++;
               end else begin
                  stalls++;
               end
            end
         end
         if (done) begin
            done_seen++;
            done_cyc    = cyc;
            err_at_done = err;
         end
      end
   end

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Reference model: plain nested loops over the tile space.
   task automatic model(input int lt, input int ic, input int oc, input int td, input int tk,
                        input longint tn, input int tot, output int n, output bit e);
      int tne;
      n = 0;
      e = (tn == 0) || (td == 0) || (tk == 0) || (ic == 0) || (oc == 0) || (tot == 0);
      if (e) return;
      tne = (tn > tot) ? tot : int'(tn);
      for (int kb = 0; kb < oc; kb += tk) begin
         for (int nb = 0; nb < tot; nb += tne) begin
            if (lt == 1) begin
               exp_q.push_back('{kb: 8'(kb), kl: 8'(imin(tk, oc - kb)), db: 8'(kb),
                                 dl: 8'(imin(tk, oc - kb)), nb: CNT_W'(nb),
                                 nl: CNT_W'(imin(tne, tot - nb)), f: 1'b1, l: 1'b1});
               n++;
            end else begin
               for (int db = 0; db < ic; db += td) begin
                  exp_q.push_back('{kb: 8'(kb), kl: 8'(imin(tk, oc - kb)), db: 8'(db),
                                    dl: 8'(imin(td, ic - db)), nb: CNT_W'(nb),
                                    nl: CNT_W'(imin(tne, tot - nb)), f: (db == 0),
                                    l: (db + td >= ic)});
                  n++;
               end
            end
         end
      end
   endtask

   task automatic apply(input int lt, input int ic, input int oc, input int td, input int tk,
                        input longint tn, input int tot);
      layer_type = 2'(lt);
      in_C       = 8'(ic);
      out_C      = 8'(oc);
      tile_D     = 8'(td);
      tile_K     = 8'(tk);
      tile_n     = 32'(tn);
      total_n    = CNT_W'(tot);
   endtask

   task automatic scramble();
      apply($urandom, $urandom, $urandom, $urandom, $urandom, longint'($urandom), $urandom);
   endtask

   task automatic run_layer(input int lt, input int ic, input int oc, input int td,
                            input int tk, input longint tn, input int tot, input int rmode);
      int n, start_cyc, waited;
      bit e;
      @(negedge clk);
      exp_q.delete();
      model(lt, ic, oc, td, tk, tn, tot, n, e);
      rdy_mode   = rmode;
      first_seen = 1'b0;
      done_seen  = 0;
      stalls     = 0;
      accepts    = 0;
      apply(lt, ic, oc, td, tk, tn, tot);
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      scramble();
      @(negedge clk);
      start = 1'b1;  // must be ignored: scheduler is no longer idle
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (done_seen == 0 && waited < 20000) begin
         @(posedge clk);
         waited++;
      end
      check("done_seen", 96'(done_seen != 0), 96'd1);
      repeat (3) @(negedge clk);
      check("done_pulses", 96'(done_seen), 96'd1);
      check("err_at_done", 96'(err_at_done), 96'(e));
      check("err_held", 96'(err), 96'(e));
      check("idle_after", 96'(busy), 96'd0);
      check("all_cmds_issued", 96'(exp_q.size()), 96'd0);
      check("accept_count", 96'(accepts), 96'(n));
      if (n == 0) begin
         check("err_done_latency", 96'(done_cyc - start_cyc), 96'd2);
         check("no_valid_seen", 96'(first_seen), 96'd0);
      end else begin
         check("done_after_last", 96'(done_cyc - last_acc_cyc), 96'd1);
         if (rmode == 1) check("back_to_back", 96'(last_acc_cyc - first_valid_cyc), 96'(n - 1));
      end
`ifdef TILE_SCHED_PERF_EN
      check("stall_cycles", 96'(stall_cycles), 96'(stalls));
      check("cmd_count", 96'(cmd_count), 96'(n));
`endif
   endtask

   initial begin
      int n;
      bit e;
      #1;
      check("reset_outputs", 96'({cmd_valid, busy, done, err, cmd_k_base, cmd_k_len, cmd_d_base,
                                  cmd_d_len, cmd_n_base, cmd_n_len, cmd_first_d, cmd_last_d}),
            96'd0);
`ifdef TILE_SCHED_PERF_EN
      check("reset_perf", 96'({stall_cycles, cmd_count}), 96'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_layer(2, 20, 16, 8, 16, 4, 10, 1);
      run_layer(2, 20, 16, 8, 16, 4, 10, 2);
      run_layer(1, 32, 32, 8, 16, 8, 8, 1);
      run_layer(2, 20, 16, 8, 16, 0, 10, 1);
      run_layer(2, 20, 16, 8, 16, 4, 10, 2);
      run_layer(0, 8, 8, 8, 8, 1000, 5, 1);
      run_layer(2, 250, 250, 130, 200, 40000, 65535, 2);
      run_layer(3, 255, 255, 255, 255, 70000, 65535, 1);

      // Reset while stalled mid-layer, then replay from the origin.
      @(negedge clk);
      exp_q.delete();
      model(2, 20, 16, 8, 16, 4, 10, n, e);
      rdy_mode   = 0;
      first_seen = 1'b0;
      apply(2, 20, 16, 8, 16, 4, 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("stalled_valid", 96'(cmd_valid), 96'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_drops_valid", 96'(cmd_valid), 96'd0);
      check("reset_drops_busy", 96'(busy), 96'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run_layer(2, 20, 16, 8, 16, 4, 10, 2);

      for (int i = 0; i < 10; i++) begin
         int ic, td, oc, tk, tot, tn;
         ic  = $urandom_range(1, 24);
         td  = $urandom_range(4, 24);
         oc  = $urandom_range(1, 24);
         tk  = $urandom_range(4, 24);
         tot = $urandom_range(1, 30);
         tn  = $urandom_range(4, 40);
         if ($urandom_range(0, 7) == 0) td = 0;
         run_layer($urandom_range(0, 3), ic, oc, td, tk, tn, tot, $urandom_range(1, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
- Consumes `tile_n` from the tile-size calculator, plus the layer's channel and tile parameters.
- Walks the full tile space of one layer and issues one tile command per tile to the downstream DMA/PE controller over a valid/ready handshake.
- Loop order: K (output-channel tiles) outer, N (pixel tiles) middle, D (input-channel tiles) inner, so partial sums accumulate across D before write-back.
- Pulses done when the layer is exhausted.

Parameters:
- CNT_W, 16: width of the pixel counters (`total_n`, `cmd_n_base`, `cmd_n_len`).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that launches a layer; ignored unless IDLE
- layer_type  in  2  0=PW, 1=DW, 2=STD, 3=LIN (`POINTWISE`, etc.)
- in_C  in  8  input channels
- out_C  in  8  output channels
- tile_D  in  8  input-channel tile size
- tile_K  in  8  output-channel tile size
- tile_n  in  32  pixels per tile, from the tile-size calculator
- total_n  in  CNT_W  output pixels in the layer
- cmd_valid  out  1  tile command valid
- cmd_ready  in  1  downstream accepts the command
- cmd_k_base  out  8  first output channel of the tile
- cmd_k_len  out  8  output channels in the tile
- cmd_d_base  out  8  first input channel of the tile
- cmd_d_len  out  8  input channels in the tile
- cmd_n_base  out  CNT_W  first pixel of the tile
- cmd_n_len  out  CNT_W  pixels in the tile
- cmd_first_d  out  1  first D tile; downstream loads bias instead of psum
- cmd_last_d  out  1  last D tile; downstream writes back output
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at layer end
- err  out  1  sticky parameter error; cleared by the next accepted start

Behaviour:
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
- Parameter latch: on start in IDLE, latch every input parameter and go to CHECK. Inputs may change afterwards without effect.
- CHECK (1 cycle):
  - If any of tile_n, tile_D, tile_K, in_C, out_C, total_n is 0, set err and go to DONE with no commands.
  - tile_n is clamped to total_n when larger, then truncated to CNT_W bits.
  - Initialise k_base = d_base = n_base = 0, then go to ISSUE.
- ISSUE:
  - cmd_valid = 1.
  - The cmd_* outputs are registered and stay stable while cmd_valid && !cmd_ready.
  - cmd_valid never drops without acceptance.
  - cmd_k_len = min(tile_K, out_C - k_base).
  - cmd_d_len = min(tile_D, in_C - d_base).
  - cmd_n_len = min(tile_n, total_n - n_base).
  - All subtractions are unsigned and are never allowed to underflow, because bases only advance while below their limit.
- Advance on acceptance (cmd_valid && cmd_ready), odometer style:
  - d_base += tile_D.
  - If d_base reaches or exceeds in_C, wrap d_base to 0 and advance n_base += tile_n.
  - If n_base reaches or exceeds total_n, wrap it to 0 and advance k_base += tile_K.
  - If k_base reaches or exceeds out_C, go to DONE.
  - The next command is presented in the cycle after acceptance, so back-to-back ready gives one command per cycle.
  - Base sums use 9-bit / CNT_W+1-bit intermediates, so wrap detection is immune to overflow.
- Depthwise (layer_type == DW):
  - There is no D loop: cmd_d_base = cmd_k_base and cmd_d_len = cmd_k_len.
  - cmd_first_d = cmd_last_d = 1.
  - Acceptance advances N, then K.
- Flags:
  - cmd_first_d = (d_base == 0).
  - cmd_last_d = (d_base + tile_D >= in_C).
- DONE (1 cycle): assert done, then return to IDLE. err holds until the next start.
- start while not IDLE is ignored.
- rst_n assertion mid-layer returns to IDLE immediately and drops cmd_valid asynchronously; no done is issued.
- Command count for non-DW layers: ceil(out_C/tile_K) * ceil(total_n/tile_n) * ceil(in_C/tile_D).

Optional Feature:
- Macro `TILE_SCHED_PERF_EN`.
- With it defined, two extra outputs are present:
  - stall_cycles (32 bits): counts cycles with cmd_valid && !cmd_ready.
  - cmd_count (32 bits): counts accepted commands.
- Both counters clear on an accepted start, saturate at all-ones, and hold their values after done.
- Without the macro, neither the ports nor the logic exist, and behaviour is otherwise identical.

Test Plan:
- STD layer, in_C=20, out_C=16, tile_D=8, tile_K=16, total_n=10, tile_n=4, ready held high:
  - 1×3×3 = 9 commands.
  - d_len sequence 8, 8, 4; n_len sequence 4, 4, 2.
  - first_d on d_base 0 only; last_d on d_base 16 only.
  - done one cycle after the 9th acceptance.
- Backpressure: same layer with cmd_ready toggled randomly:
  - cmd_* stay stable while stalled.
  - Still exactly 9 distinct commands, in order.
  - With `TILE_SCHED_PERF_EN`, stall_cycles equals the number of stalled cycles.
- DW layer, out_C=in_C=32, tile_K=16, total_n=8, tile_n=8:
  - 2 commands, with d_base == k_base (0, then 16).
  - first_d = last_d = 1 on both.
- tile_n=0 with otherwise valid parameters:
  - No cmd_valid.
  - err=1 and a done pulse 2 cycles after start.
  - The next valid start clears err.
- tile_n = 1000 > total_n = 5: a single N tile with n_len=5.
- Reset mid-layer: assert rst_n=0 while stalled in ISSUE:
  - cmd_valid drops immediately and busy=0.
  - A following start replays from k_base = n_base = d_base = 0.
